// File: rtl/filter_switch.sv
// filter_switch
//   Frame-synchronous selector between a bypass path and NUM_ENG filter engines.
//   A requested mode is armed at the next input frame sync, the output is muted
//   while the new source warms up, and it is released on that source's first
//   frame sync (or after TIMEOUT muted cycles if the source never starts).
//   Optional feature macro: FSW_BYPASS_ALIGN_EN -- when defined, the bypass
//   stream is delayed by BYP_LAT stages so its latency matches the engines.
module filter_switch #(
  parameter int DATA_W  = 24,
  parameter int NUM_ENG = 3,
  parameter int MODE_W  = 2,
  parameter int BYP_LAT = 2,
  parameter int TIMEOUT = 2**22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MODE_W-1:0]         mode_req,
  input  logic                      pre_vs,
  input  logic                      pre_de,
  input  logic [DATA_W-1:0]         pre_data,
  output logic [NUM_ENG-1:0]        eng_en,
  input  logic [NUM_ENG-1:0]        eng_vs,
  input  logic [NUM_ENG-1:0]        eng_de,
  input  logic [NUM_ENG*DATA_W-1:0] eng_data,
  output logic                      post_vs,
  output logic                      post_de,
  output logic [DATA_W-1:0]         post_data,
  output logic [MODE_W-1:0]         mode_act,
  output logic                      busy
);

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_ENG);

  // Elaboration-time guards on the configuration.
  if (NUM_ENG < 1 || NUM_ENG > (2**MODE_W) - 1) begin : g_bad_num_eng
    $error("filter_switch: NUM_ENG must be in 1..2**MODE_W-1");
  end
  if (BYP_LAT < 1) begin : g_bad_byp_lat
    $error("filter_switch: BYP_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_RUN,   // output follows mode_act
    S_PEND,  // change requested, waiting for an input frame sync
    S_MUTE   // new source enabled, output held at zero until it starts a frame
  } state_t;

  state_t              r_state;
  logic [MODE_W-1:0]   r_req_q;
  logic [MODE_W-1:0]   r_tgt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pre_vs_d;
  logic [NUM_ENG-1:0]  r_eng_vs_d;

  logic [MODE_W-1:0]   w_req;
  logic [NUM_ENG-1:0]  w_req_onehot;
  logic [MODE_W-1:0]   w_sel;
  logic                w_vs_rise;
  logic                w_src_rise;
  logic                w_commit;

  logic                w_byp_vs;
  logic                w_byp_vs_d;
  logic                w_byp_de;
  logic [DATA_W-1:0]   w_byp_data;

  logic                w_src_vs;
  logic                w_src_vs_d;
  logic                w_src_de;
  logic [DATA_W-1:0]   w_src_data;

`ifdef FSW_BYPASS_ALIGN_EN
  logic [BYP_LAT-1:0]  r_byp_vs;
  logic [BYP_LAT-1:0]  r_byp_de;
  logic [DATA_W-1:0]   r_byp_data [BYP_LAT];
  logic                r_byp_vs_d;

  // Delay line that aligns the bypass stream with the engine latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is cleared on reset so no stale pixels leak out after a reset.
      r_byp_vs   <= '0;
      r_byp_de   <= '0;
      r_byp_vs_d <= 1'b0;
      for (int i = 0; i < BYP_LAT; i++) r_byp_data[i] <= '0;
    end else begin
      r_byp_vs[0]   <= pre_vs;
      r_byp_de[0]   <= pre_de;
      r_byp_data[0] <= pre_data;
      for (int i = 1; i < BYP_LAT; i++) begin
        r_byp_vs[i]   <= r_byp_vs[i-1];
        r_byp_de[i]   <= r_byp_de[i-1];
        r_byp_data[i] <= r_byp_data[i-1];
      end
      r_byp_vs_d <= r_byp_vs[BYP_LAT-1];
    end
  end

  assign w_byp_vs   = r_byp_vs[BYP_LAT-1];
  assign w_byp_vs_d = r_byp_vs_d;
  assign w_byp_de   = r_byp_de[BYP_LAT-1];
  assign w_byp_data = r_byp_data[BYP_LAT-1];
`else
  assign w_byp_vs   = pre_vs;
  assign w_byp_vs_d = r_pre_vs_d;
  assign w_byp_de   = pre_de;
  assign w_byp_data = pre_data;
`endif

  // Clamp the registered request and build its one-hot engine enable.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_req        = (r_req_q > MODE_MAX) ? '0 : r_req_q;
    w_req_onehot = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      w_req_onehot[i] = (w_req == MODE_W'(i + 1));
    end
  end

  // Pick the active source: the target while muted, otherwise the committed mode.
  always_comb begin
    w_sel      = (r_state == S_MUTE) ? r_tgt : mode_act;
    w_src_vs   = w_byp_vs;
    w_src_vs_d = w_byp_vs_d;
    w_src_de   = w_byp_de;
    w_src_data = w_byp_data;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (w_sel == MODE_W'(i + 1)) begin
        w_src_vs   = eng_vs[i];
        w_src_vs_d = r_eng_vs_d[i];
        w_src_de   = eng_de[i];
        w_src_data = eng_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_vs_rise  = pre_vs & ~r_pre_vs_d;
  assign w_src_rise = w_src_vs & ~w_src_vs_d;
  assign w_commit   = (r_state == S_MUTE) && (w_src_rise || (r_cnt == CNT_MAX));

  // Mode FSM with the registered output stage and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_req_q    <= '0;
      r_tgt      <= '0;
      r_cnt      <= '0;
      r_pre_vs_d <= 1'b0;
      r_eng_vs_d <= '0;
      eng_en     <= '0;
      post_vs    <= 1'b0;
      post_de    <= 1'b0;
      post_data  <= '0;
      mode_act   <= '0;
      busy       <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
      r_req_q    <= mode_req;
      r_pre_vs_d <= pre_vs;
      r_eng_vs_d <= eng_vs;

      if (r_state == S_MUTE && !w_commit) begin
        post_vs   <= 1'b0;
        post_de   <= 1'b0;
        post_data <= '0;
      end else begin
        post_vs   <= w_src_vs;
        post_de   <= w_src_de;
        post_data <= w_src_data;
      end

      case (r_state)
        S_RUN: begin
          if (w_req != mode_act) begin
            r_state <= S_PEND;
            busy    <= 1'b1;
          end
        end
        S_PEND: begin
          if (w_req == mode_act) begin
            r_state <= S_RUN;
            busy    <= 1'b0;
          end else if (w_vs_rise) begin
            r_tgt   <= w_req;
            eng_en  <= w_req_onehot;
            r_cnt   <= '0;
            r_state <= S_MUTE;
          end
        end
        S_MUTE: begin
          if (w_commit) begin
            mode_act <= r_tgt;
            r_state  <= S_RUN;
            busy     <= 1'b0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_RUN;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
